// File: rtl/pio_shift_out.sv
// Serialises a PIO parallel output onto a 74HC595-style chain (SCLK/SER/RCLK/OE_n).
// A value is shifted and latched once per change, plus once forced after reset.
module pio_shift_out #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_port,
  output logic              sr_sclk,
  output logic              sr_data,
  output logic              sr_latch,
  output logic              sr_oe_n,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t              state_reg, state_next;
  logic [DIV_W-1:0]    div_reg, div_next;
  logic [CNT_W-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0]   sreg_reg, sreg_next;
  logic [DATA_W-1:0]   shadow_reg, shadow_next;
  logic                init_pend_reg, init_pend_next;
  logic                data_reg, data_next;
  logic                oe_n_reg, oe_n_next;
  logic                sclk_reg, latch_reg, busy_reg, done_reg;

  logic                pending;
  logic                div_last;
  logic                first_bit;
  logic                next_bit;
  logic [DATA_W-1:0]   shifted;

  // The bit presented to SER is always the head of sreg after shifting.
  assign shifted   = (MSB_FIRST != 0) ? (sreg_reg << 1) : (sreg_reg >> 1);
  assign next_bit  = (MSB_FIRST != 0) ? shifted[DATA_W-1] : shifted[0];
  assign first_bit = (MSB_FIRST != 0) ? in_port[DATA_W-1] : in_port[0];
  assign pending   = init_pend_reg | (in_port != shadow_reg);
  assign div_last  = (div_reg == DIV_LAST);

  always_comb begin
    state_next     = state_reg;
    div_next       = div_reg;
    bit_cnt_next   = bit_cnt_reg;
    sreg_next      = sreg_reg;
    shadow_next    = shadow_reg;
    init_pend_next = init_pend_reg;
    data_next      = data_reg;
    oe_n_next      = oe_n_reg;
    case (state_reg)
      IDLE: begin
        if (pending) begin
          sreg_next      = in_port;
          shadow_next    = in_port;
          init_pend_next = 1'b0;
          bit_cnt_next   = '0;
          data_next      = first_bit;
          div_next       = '0;
          state_next     = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_next   = '0;
          state_next = SHIFT_HI;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_next = '0;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = LATCH;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            sreg_next    = shifted;
            data_next    = next_bit;
            state_next   = SHIFT_LO;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      LATCH: begin
        if (div_last) begin
          div_next   = '0;
          oe_n_next  = 1'b0;
          state_next = IDLE;
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so no in_port path reaches a pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      div_reg       <= '0;
      bit_cnt_reg   <= '0;
      sreg_reg      <= '0;
      shadow_reg    <= '0;
      init_pend_reg <= 1'b1;
      data_reg      <= 1'b0;
      oe_n_reg      <= 1'b1;
      sclk_reg      <= 1'b0;
      latch_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      div_reg       <= div_next;
      bit_cnt_reg   <= bit_cnt_next;
      sreg_reg      <= sreg_next;
      shadow_reg    <= shadow_next;
      init_pend_reg <= init_pend_next;
      data_reg      <= data_next;
      oe_n_reg      <= oe_n_next;
      sclk_reg      <= (state_next == SHIFT_HI);
      latch_reg     <= (state_next == LATCH);
      busy_reg      <= (state_next != IDLE);
      done_reg      <= (state_next == LATCH) && (div_next == DIV_LAST);
    end
  end

  assign sr_sclk  = sclk_reg;
  assign sr_data  = data_reg;
  assign sr_latch = latch_reg;
  assign sr_oe_n  = oe_n_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_pio_shift_out.sv
// Bench for pio_shift_out: a monitor rebuilds each latched word from SCLK/SER and
// checks it against a queue of expected words pushed by the stimulus process.
module tb_pio_shift_out;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] in_port = 8'h00;
  logic       sr_sclk, sr_data, sr_latch, sr_oe_n, busy, done;

  logic       reset2_n = 1'b1;
  logic [7:0] in_port2 = 8'h01;
  logic       sclk2, data2, latch2, oe_n2, busy2, done2;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         latch_count = 0;
  int         sclk_rises = 0;
  int         mon_bits = 0;

  always #5 clk = ~clk;

  pio_shift_out #(.DATA_W(8), .CLK_DIV(4), .MSB_FIRST(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_port(in_port),
    .sr_sclk(sr_sclk), .sr_data(sr_data), .sr_latch(sr_latch),
    .sr_oe_n(sr_oe_n), .busy(busy), .done(done)
  );

  pio_shift_out #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(0)) dut2 (
    .clk(clk), .reset_n(reset2_n), .in_port(in_port2),
    .sr_sclk(sclk2), .sr_data(data2), .sr_latch(latch2),
    .sr_oe_n(oe_n2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: sample away from the rising edge, on the falling clock edge.
  logic       prev_sclk = 1'b0;
  logic       prev_latch = 1'b0;
  logic [7:0] mon_word = 8'h00;
  int         latch_cycles = 0;
  int         done_seen = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      mon_bits     = 0;
      mon_word     = 8'h00;
      latch_cycles = 0;
      done_seen    = 0;
    end else begin
      if (sr_sclk && !prev_sclk) begin
        mon_word = {mon_word[6:0], sr_data};
        mon_bits++;
        sclk_rises++;
      end
      if (sr_latch && !prev_latch) begin
        latch_count++;
        latch_cycles = 1;
        done_seen    = done ? 1 : 0;
        check("bits_per_transfer", mon_bits, 8);
        if (exp_q.size() == 0) begin
          check("unexpected_latch", {24'h0, mon_word}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          $display("latch word=%02h expected=%02h", mon_word, e);
          check("latched_word", {24'h0, mon_word}, {24'h0, e});
        end
        mon_bits = 0;
        mon_word = 8'h00;
      end else if (sr_latch) begin
        latch_cycles++;
        if (done) done_seen++;
      end else if (prev_latch) begin
        check("latch_len", latch_cycles, 4);
        check("done_pulses", done_seen, 1);
      end
    end
    prev_sclk  = sr_sclk;
    prev_latch = sr_latch;
  end

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 500) begin @(posedge clk); #1; n++; end
    if (!busy) check({name, "_busy_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 500) begin @(posedge clk); #1; n++; end
    if (busy) check({name, "_idle_timeout"}, 1, 0);
  endtask

  initial begin
    int n, bad, lc0, sr0, rises, cnt;
    logic p, word;
    logic [7:0] w2;

    // Reset values and forced first transfer of A5
    in_port = 8'hA5;
    #1 reset_n = 1'b0;
    #1 reset2_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset_outputs", {26'h0, sr_sclk, sr_data, sr_latch, sr_oe_n, busy, done}, 32'h04);
    exp_q.push_back(8'hA5);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    check("busy_rise_after_reset", busy, 1);
    n = 0;
    while (sr_oe_n && n < 300) begin @(posedge clk); #1; n++; end
    check("oe_fall_cycles", n, 68);
    check("busy_after_first", busy, 0);

    // Unchanged value: nothing happens for 1000 cycles
    sr0 = sclk_rises; bad = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (busy || sr_oe_n) bad++;
    end
    check("idle_hold_violations", bad, 0);
    check("idle_hold_sclk_rises", sclk_rises - sr0, 0);

    // 3C transfer with 81 then FF arriving mid-transfer
    lc0 = latch_count;
    in_port = 8'h3C; exp_q.push_back(8'h3C);
    wait_busy("t3c");
    repeat (10) @(posedge clk);
    #1 in_port = 8'h81;
    repeat (20) @(posedge clk);
    #1 in_port = 8'hFF; exp_q.push_back(8'hFF);
    wait_idle("t3c");
    @(posedge clk); #1;
    check("back_to_back_start", busy, 1);
    wait_idle("tff");
    repeat (200) @(posedge clk);
    #1 check("t3c_latches", latch_count - lc0, 2);
    check("t3c_queue_empty", exp_q.size(), 0);

    // A5 transfer; in_port bounces to 5A and back before IDLE
    lc0 = latch_count;
    in_port = 8'hA5; exp_q.push_back(8'hA5);
    wait_busy("ta5");
    in_port = 8'h5A;
    repeat (30) @(posedge clk);
    #1 in_port = 8'hA5;
    wait_idle("ta5");
    repeat (200) @(posedge clk);
    #1 check("bounce_latches", latch_count - lc0, 1);
    check("bounce_queue_empty", exp_q.size(), 0);

    // Reset during bit 4 of a C3 transfer
    lc0 = latch_count;
    in_port = 8'hC3;
    wait_busy("tc3");
    n = 0;
    while (mon_bits < 5 && n < 500) begin @(posedge clk); #1; n++; end
    check("reached_bit4", mon_bits, 5);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 check("async_reset_outputs", {26'h0, sr_sclk, sr_data, sr_latch, sr_oe_n, busy, done}, 32'h04);
    repeat (3) @(posedge clk);
    #2 check("no_latch_in_reset", latch_count - lc0, 0);
    exp_q.push_back(8'hC3);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("busy_after_rereset", busy, 1);
    n = 0;
    while (sr_oe_n && n < 300) begin @(posedge clk); #1; n++; end
    check("rereset_oe_cycles", n, 68);
    repeat (20) @(posedge clk);
    #1 check("rereset_latches", latch_count - lc0, 1);
    check("rereset_queue_empty", exp_q.size(), 0);

    // CLK_DIV=1, LSB first, value 01
    @(posedge clk); #2;
    reset2_n = 1'b1;
    @(posedge clk); #1;
    check("d2_busy_rise", busy2, 1);
    cnt = 0; p = 1'b0; rises = 0; bad = 0; w2 = 8'h00;
    while (busy2 && cnt < 100) begin
      if (cnt > 0 && cnt <= 16 && sclk2 == p) bad++;
      if (sclk2 && !p) begin
        w2 = {data2, w2[7:1]};
        rises++;
      end
      p = sclk2;
      @(posedge clk); #1;
      cnt++;
    end
    word = 1'b0;
    $display("d2 transfer cycles=%0d rises=%0d word=%02h", cnt, rises, w2);
    check("d2_transfer_len", cnt, 17);
    check("d2_sclk_toggle_bad", bad, 0);
    check("d2_rises", rises, 8);
    check("d2_word", {24'h0, w2}, 32'h01);
    check("d2_oe_n", {31'h0, oe_n2}, {31'h0, word});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
